// File: rtl/nbbpu_pkg.sv
// Shared NBBPU register-file types: widths, register count, scoreboard counter width
// and the writeback requester encoding.
package nbbpu_pkg;
  localparam int DATA_WIDTH     = 16;
  localparam int ADDR_WIDTH     = 4;
  localparam int REG_COUNT      = 16;
  localparam int SB_COUNT_WIDTH = 2;

  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_LOAD = 1'b1
  } requester_t;
endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback, reservation, hazard-query and regfile write-port bundle.
// The master side is the pipeline; the slave side is the arbiter.
interface regfile_writeback_arbiter_if;
  import nbbpu_pkg::*;

  logic                  exec_valid;
  logic                  exec_ready;
  logic [ADDR_WIDTH-1:0] exec_address;
  logic [DATA_WIDTH-1:0] exec_data;

  logic                  load_valid;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] load_address;
  logic [DATA_WIDTH-1:0] load_data;

  logic                  mark_valid;
  logic                  mark_ready;
  logic [ADDR_WIDTH-1:0] mark_address;

  logic [ADDR_WIDTH-1:0] query_address_1;
  logic [ADDR_WIDTH-1:0] query_address_2;
  logic                  busy_1;
  logic                  busy_2;
  logic                  forward_valid_1;
  logic                  forward_valid_2;
  logic [DATA_WIDTH-1:0] forward_data_1;
  logic [DATA_WIDTH-1:0] forward_data_2;

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address_write;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output exec_valid, exec_address, exec_data,
    input  exec_ready,
    output load_valid, load_address, load_data,
    input  load_ready,
    output mark_valid, mark_address,
    input  mark_ready,
    output query_address_1, query_address_2,
    input  busy_1, busy_2, forward_valid_1, forward_valid_2, forward_data_1, forward_data_2,
    input  write_enable, address_write, write_data
  );

  modport slave (
    input  exec_valid, exec_address, exec_data,
    output exec_ready,
    input  load_valid, load_address, load_data,
    output load_ready,
    input  mark_valid, mark_address,
    output mark_ready,
    input  query_address_1, query_address_2,
    output busy_1, busy_2, forward_valid_1, forward_valid_2, forward_data_1, forward_data_2,
    output write_enable, address_write, write_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register outstanding-write counters: mark increments, commit decrements, busy lookup.
// Counter updates land at the clock edge; mark_ready stalls a reservation when the counter is full.
module regfile_scoreboard
  import nbbpu_pkg::*;
#(
  parameter int unsigned SB_MAX = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mark_valid,
  output logic                  mark_ready,
  input  logic [ADDR_WIDTH-1:0] mark_address,
  input  logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] commit_address,
  input  logic [ADDR_WIDTH-1:0] query_address_1,
  input  logic [ADDR_WIDTH-1:0] query_address_2,
  input  logic                  hit_1,
  input  logic                  hit_2,
  output logic                  busy_1,
  output logic                  busy_2
);
  localparam logic [SB_COUNT_WIDTH-1:0] COUNT_MAX = SB_COUNT_WIDTH'(SB_MAX);
  localparam logic [SB_COUNT_WIDTH-1:0] COUNT_ONE = SB_COUNT_WIDTH'(1);

  logic [SB_COUNT_WIDTH-1:0] count_q [REG_COUNT];
  logic [SB_COUNT_WIDTH-1:0] count_d [REG_COUNT];
  logic                      mark_accept;
  logic                      commit_same;

  always_comb begin
    commit_same = commit_valid && (commit_address == mark_address);
    mark_ready  = !((count_q[mark_address] == COUNT_MAX) && !commit_same);
    mark_accept = mark_valid && mark_ready;
  end

  // r0 is never reserved, so its counter only ever sees clamped decrements.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      count_d[i] = count_q[i];
      if (mark_accept && (mark_address == ADDR_WIDTH'(i)) && (i != 0)) begin
        if (!(commit_valid && (commit_address == ADDR_WIDTH'(i))))
          count_d[i] = count_q[i] + COUNT_ONE;
      end else if (commit_valid && (commit_address == ADDR_WIDTH'(i)) && (count_q[i] != '0)) begin
        count_d[i] = count_q[i] - COUNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < REG_COUNT; i++) begin
      if (reset) count_q[i] <= '0;
      else       count_q[i] <= count_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && commit_valid && (commit_address != '0) &&
        !(mark_accept && (mark_address == commit_address)))
      assert (count_q[commit_address] != '0)
        else $error("scoreboard underflow on r%0d", commit_address);
  end

  // A bypass hit on the last outstanding write resolves the hazard this cycle.
  always_comb begin
    busy_1 = (query_address_1 != '0) && (count_q[query_address_1] != '0) &&
             !(hit_1 && (count_q[query_address_1] == COUNT_ONE));
    busy_2 = (query_address_2 != '0) && (count_q[query_address_2] != '0) &&
             !(hit_2 && (count_q[query_address_2] == COUNT_ONE));
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin arbiter of exec/load writebacks onto the regfile write port, plus RAW scoreboard.
// One cycle accept-to-write; ready only to the granted requester; optional REGFILE_ARB_BYPASS_EN forwarding.
module regfile_writeback_arbiter
  import nbbpu_pkg::*;
#(
  parameter int unsigned SB_MAX = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  regfile_writeback_arbiter_if.slave  bus
);
  requester_t            last_grant_q;
  requester_t            last_grant_d;
  logic                  exec_grant;
  logic                  load_grant;
  logic                  stage_valid;
  logic [ADDR_WIDTH-1:0] stage_address;
  logic [DATA_WIDTH-1:0] stage_data;
  logic                  hit_1;
  logic                  hit_2;

  always_comb begin
    exec_grant   = bus.exec_valid && (!bus.load_valid || (last_grant_q == REQ_LOAD));
    load_grant   = bus.load_valid && !exec_grant;
    last_grant_d = last_grant_q;
    if (exec_grant)      last_grant_d = REQ_EXEC;
    else if (load_grant) last_grant_d = REQ_LOAD;
  end

  assign bus.exec_ready = exec_grant;
  assign bus.load_ready = load_grant;

  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= REQ_LOAD;
    else       last_grant_q <= last_grant_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid   <= 1'b0;
      stage_address <= '0;
      stage_data    <= '0;
    end else begin
      stage_valid <= exec_grant || load_grant;
      if (exec_grant) begin
        stage_address <= bus.exec_address;
        stage_data    <= bus.exec_data;
      end else if (load_grant) begin
        stage_address <= bus.load_address;
        stage_data    <= bus.load_data;
      end
    end
  end

  // Writes to r0 still commit to the scoreboard but never reach the regfile.
  assign bus.write_enable  = stage_valid && (stage_address != '0);
  assign bus.address_write = stage_address;
  assign bus.write_data    = stage_data;

  always_comb begin
    hit_1               = 1'b0;
    hit_2               = 1'b0;
    bus.forward_valid_1 = 1'b0;
    bus.forward_valid_2 = 1'b0;
    bus.forward_data_1  = '0;
    bus.forward_data_2  = '0;
`ifdef REGFILE_ARB_BYPASS_EN
    hit_1 = bus.write_enable && (stage_address == bus.query_address_1) && (bus.query_address_1 != '0);
    hit_2 = bus.write_enable && (stage_address == bus.query_address_2) && (bus.query_address_2 != '0);
    bus.forward_valid_1 = hit_1;
    bus.forward_valid_2 = hit_2;
    if (hit_1) bus.forward_data_1 = stage_data;
    if (hit_2) bus.forward_data_2 = stage_data;
`else
    hit_1 = 1'b0;
    hit_2 = 1'b0;
`endif
  end

  regfile_scoreboard #(
    .SB_MAX (SB_MAX)
  ) u_scoreboard (
    .clock           (clock),
    .reset           (reset),
    .mark_valid      (bus.mark_valid),
    .mark_ready      (bus.mark_ready),
    .mark_address    (bus.mark_address),
    .commit_valid    (stage_valid),
    .commit_address  (stage_address),
    .query_address_1 (bus.query_address_1),
    .query_address_2 (bus.query_address_2),
    .hit_1           (hit_1),
    .hit_2           (hit_2),
    .busy_1          (bus.busy_1),
    .busy_2          (bus.busy_2)
  );
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter; expected regfile writes are queued at accept time.
// Honours REGFILE_ARB_BYPASS_EN when compiled with it.
module tb_regfile_writeback_arbiter;
  import nbbpu_pkg::*;

`ifdef REGFILE_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  always #5 clock = ~clock;

  regfile_writeback_arbiter_if bus ();

  regfile_writeback_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mark(input logic [ADDR_WIDTH-1:0] a);
    bus.mark_valid   = 1'b1;
    bus.mark_address = a;
    settle();
    check("mark_ready_accept", bus.mark_ready, 1'b1);
    cyc();
    bus.mark_valid = 1'b0;
  endtask

  // Every regfile write must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.write_enable === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_write observed addr=%0d data=0x%0h expected no write",
               bus.address_write, bus.write_data);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.address_write, e.addr);
        check("wr_data", bus.write_data, e.data);
      end
    end
  end

  initial begin
    reset               = 1'b1;
    bus.exec_valid      = 1'b0;
    bus.exec_address    = '0;
    bus.exec_data       = '0;
    bus.load_valid      = 1'b0;
    bus.load_address    = '0;
    bus.load_data       = '0;
    bus.mark_valid      = 1'b0;
    bus.mark_address    = '0;
    bus.query_address_1 = 4'd3;
    bus.query_address_2 = 4'd5;
    repeat (3) cyc();
    settle();
    check("rst_we", bus.write_enable, 1'b0);
    check("rst_addr", bus.address_write, 4'd0);
    check("rst_data", bus.write_data, 16'h0000);
    check("rst_busy1", bus.busy_1, 1'b0);
    check("rst_busy2", bus.busy_2, 1'b0);
    check("rst_fv1", bus.forward_valid_1, 1'b0);
    check("rst_fd1", bus.forward_data_1, 16'h0000);
    check("rst_mark_ready", bus.mark_ready, 1'b1);
    check("rst_exec_ready", bus.exec_ready, 1'b0);
    reset = 1'b0;
    cyc();

    // Round-robin with both requesters held valid
    mark(4'd2);
    mark(4'd2);
    mark(4'd5);
    mark(4'd5);
    bus.query_address_1 = 4'd2;
    bus.query_address_2 = 4'd5;
    settle();
    check("rr_busy_r2", bus.busy_1, 1'b1);
    check("rr_busy_r5", bus.busy_2, 1'b1);
    bus.exec_valid   = 1'b1;
    bus.exec_address = 4'd2;
    bus.exec_data    = 16'h0002;
    bus.load_valid   = 1'b1;
    bus.load_address = 4'd5;
    bus.load_data    = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_exec_ready", bus.exec_ready, (i % 2) == 0);
      check("rr_load_ready", bus.load_ready, (i % 2) == 1);
      if ((i % 2) == 0) push(4'd2, 16'h0002);
      else              push(4'd5, 16'h0005);
      cyc();
    end
    bus.exec_valid = 1'b0;
    bus.load_valid = 1'b0;
    cyc();
    settle();
    check("rr_busy_r2_clear", bus.busy_1, 1'b0);
    check("rr_busy_r5_clear", bus.busy_2, 1'b0);

    // Single exec write, one-cycle latency
    mark(4'd3);
    bus.query_address_1 = 4'd3;
    bus.exec_valid      = 1'b1;
    bus.exec_address    = 4'd3;
    bus.exec_data       = 16'h1234;
    settle();
    check("ex_exec_ready", bus.exec_ready, 1'b1);
    check("ex_load_ready", bus.load_ready, 1'b0);
    check("ex_busy_before", bus.busy_1, 1'b1);
    push(4'd3, 16'h1234);
    cyc();
    bus.exec_valid = 1'b0;
    settle();
    check("ex_we_n1", bus.write_enable, 1'b1);
    check("ex_addr_n1", bus.address_write, 4'd3);
    check("ex_data_n1", bus.write_data, 16'h1234);
    cyc();
    settle();
    check("ex_we_n2", bus.write_enable, 1'b0);
    check("ex_busy_n2", bus.busy_1, 1'b0);

    // Saturate r4, then drain it with loads
    mark(4'd4);
    mark(4'd4);
    mark(4'd4);
    bus.mark_address    = 4'd4;
    bus.query_address_1 = 4'd4;
    settle();
    check("sat_mark_ready", bus.mark_ready, 1'b0);
    check("sat_busy", bus.busy_1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.load_valid   = 1'b1;
      bus.load_address = 4'd4;
      bus.load_data    = 16'(16'h4440 + k);
      settle();
      check("sat_load_ready", bus.load_ready, 1'b1);
      push(4'd4, 16'(16'h4440 + k));
      cyc();
      bus.load_valid = 1'b0;
      settle();
      check("sat_mark_ready_commit", bus.mark_ready, 1'b1);
      check("sat_busy_commit", bus.busy_1, (BYP && k == 2) ? 1'b0 : 1'b1);
      cyc();
      settle();
      check("sat_busy_after", bus.busy_1, k < 2);
    end

    // r0 is never written and never busy
    mark(4'd0);
    bus.query_address_1 = 4'd0;
    bus.exec_valid      = 1'b1;
    bus.exec_address    = 4'd0;
    bus.exec_data       = 16'hFFFF;
    settle();
    check("r0_exec_ready", bus.exec_ready, 1'b1);
    check("r0_busy", bus.busy_1, 1'b0);
    cyc();
    bus.exec_valid = 1'b0;
    settle();
    check("r0_we", bus.write_enable, 1'b0);
    check("r0_busy_commit", bus.busy_1, 1'b0);
    cyc();

    // Reset during the output stage of an accepted write
    mark(4'd6);
    mark(4'd6);
    bus.query_address_1 = 4'd6;
    bus.query_address_2 = 4'd2;
    bus.exec_valid      = 1'b1;
    bus.exec_address    = 4'd6;
    bus.exec_data       = 16'h6666;
    settle();
    check("mid_exec_ready", bus.exec_ready, 1'b1);
    push(4'd6, 16'h6666);
    cyc();
    bus.exec_data = 16'h7777;
    reset         = 1'b1;
    settle();
    check("mid_we_before_rst", bus.write_enable, 1'b1);
    cyc();
    bus.exec_valid = 1'b0;
    reset          = 1'b0;
    settle();
    check("mid_we_after_rst", bus.write_enable, 1'b0);
    check("mid_busy1", bus.busy_1, 1'b0);
    check("mid_busy2", bus.busy_2, 1'b0);
    check("mid_mark_ready", bus.mark_ready, 1'b1);

    // Bypass on commit; first contest after reset goes to exec
    mark(4'd7);
    mark(4'd1);
    bus.query_address_1 = 4'd7;
    bus.query_address_2 = 4'd1;
    bus.exec_valid      = 1'b1;
    bus.exec_address    = 4'd7;
    bus.exec_data       = 16'hBEEF;
    bus.load_valid      = 1'b1;
    bus.load_address    = 4'd1;
    bus.load_data       = 16'h0101;
    settle();
    check("byp_exec_first", bus.exec_ready, 1'b1);
    check("byp_load_waits", bus.load_ready, 1'b0);
    push(4'd7, 16'hBEEF);
    cyc();
    bus.exec_valid = 1'b0;
    settle();
    check("byp_load_ready", bus.load_ready, 1'b1);
    push(4'd1, 16'h0101);
    check("byp_fv1", bus.forward_valid_1, BYP);
    check("byp_fd1", bus.forward_data_1, BYP ? 16'hBEEF : 16'h0000);
    check("byp_busy1", bus.busy_1, !BYP);
    cyc();
    bus.load_valid = 1'b0;
    settle();
    check("byp_busy1_after", bus.busy_1, 1'b0);
    check("byp_fv2", bus.forward_valid_2, BYP);
    check("byp_fd2", bus.forward_data_2, BYP ? 16'h0101 : 16'h0000);
    check("byp_busy2", bus.busy_2, !BYP);
    cyc();
    settle();
    check("byp_busy2_after", bus.busy_2, 1'b0);
    check("byp_fv1_idle", bus.forward_valid_1, 1'b0);

    repeat (2) cyc();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Shares the single write port of the NBBPU 16 x 16-bit register file between two writeback requesters, the execute unit (ALU results) and the load unit (memory data), using round-robin arbitration. Also keeps a per-register scoreboard of outstanding writes, which the decode stage queries to stall on read-after-write hazards. Sits between the execute/load pipeline stages and the register file write port; its write outputs drive the regfile directly.

## Interface
- DATA_WIDTH, 16, register width
- ADDR_WIDTH, 4, register address width (16 registers)
- SB_MAX, 3, maximum outstanding writes tracked per register
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- exec_valid / exec_ready  in/out  1  execute writeback handshake
- exec_address / exec_data  in  4/16  execute destination and result
- load_valid / load_ready  in/out  1  load writeback handshake
- load_address / load_data  in  4/16  load destination and data
- mark_valid / mark_ready  in/out  1  decode reserves a destination register
- mark_address  in  4  register being reserved
- query_address_1 / query_address_2  in  4  decode source operands
- busy_1 / busy_2  out  1  source has outstanding write(s)
- forward_valid_1 / forward_valid_2  out  1  bypass hit (see Configuration)
- forward_data_1 / forward_data_2  out  16  bypass data
- write_enable  out  1  to regfile
- address_write  out  4  to regfile
- write_data  out  16  to regfile

## Operation
- Transfer occurs when valid && ready in the same cycle. Valid and payload must be held until the transfer.
- At most one writeback is accepted per cycle. ready is asserted combinationally to the granted requester only. The regfile always accepts, so there is no back-pressure from the output.
- Arbitration: if only one requester is valid, it is granted. If both are valid, the requester opposite last_grant is granted. last_grant updates on every accepted transfer. Reset value of last_grant = load, so exec wins the first contest.
- Accepted writeback is registered into the output stage. write_enable = 1 the following cycle unless address = 0. A write to r0 is accepted and consumed, write_enable stays 0, and it still decrements the r0 scoreboard.
- Scoreboard: one 2-bit counter per register.
  - Accepted mark increments the counter.
  - Commit (output stage valid) decrements it.
  - Mark and commit to the same register in the same cycle leave it unchanged.
  - mark_ready = 0 when the counter of mark_address = SB_MAX and no same-cycle commit targets it.
  - Marks to r0 are accepted and ignored.
- busy_n = counter[query_address_n] != 0. Always 0 for address 0.
- Decrementing a counter already at 0 is an upstream error. The counter holds at 0 (under simulation an assertion fires).

## Timing
- Latency: accepted in cycle N, regfile write_enable high in cycle N+1, register contents updated at the end of N+1, readable in N+2.
- Scoreboard counter decrements at the end of N+1. busy falls in N+2.
- Reset values: write_enable 0, address_write 0, write_data 0, all counters 0, busy 0, forward_valid 0, forward_data 0, exec_ready/load_ready/mark_ready follow their combinational rules.
- Reset mid-operation: the pending output stage is discarded (no write in the cycle after reset) and all counters clear. Requesters must re-issue.
- Simultaneous mark and commit of different registers are both applied.

## Configuration
- REGFILE_ARB_BYPASS_EN defined:
  - forward_valid_n = 1 when write_enable && address_write == query_address_n != 0, with forward_data_n = write_data.
  - busy_n is suppressed when that hit occurs and the counter equals 1.
- Undefined: forward_valid_n and forward_data_n are tied 0, and busy follows the counter only.

## Structure
- Shared package nbbpu_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, REG_COUNT = 16, SB_COUNT_WIDTH = 2
  - requester enum {REQ_EXEC, REQ_LOAD}
- Sub-module regfile_scoreboard: the counter array, mark_ready, and busy lookup, with inputs mark/commit/query.

## Test plan
- Exec-only write r3 = 0x1234 at cycle 1 -> cycle 2: write_enable = 1, address_write = 3, write_data = 0x1234. Cycle 3: write_enable = 0.
- exec (r2, 0x0002) and load (r5, 0x0005) both held valid for 4 cycles -> grants exec, load, exec, load; regfile writes alternate r2/r5.
- Mark r4 three times -> mark_ready = 0 and busy for r4 = 1. One load to r4 commits -> mark_ready = 1, busy stays 1 until the third commit.
- Exec write to r0 with data 0xFFFF -> exec_ready = 1, write_enable stays 0, busy for r0 is always 0.
- Reset asserted in the cycle after an accepted write -> write_enable = 0 the next cycle, all busy = 0.
- With REGFILE_ARB_BYPASS_EN, r7 marked once, query_address_1 = 7 while write_enable commits r7 = 0xBEEF -> forward_valid_1 = 1, forward_data_1 = 0xBEEF, busy_1 = 0. Without the macro -> busy_1 = 1, forward_valid_1 = 0.
